svfloat_msb_pipe: RTL and testbench

Pipelined, parametrised bit-index finder and normaliser for the svfloat datapath. Each transaction finds either the most-significant or the least-significant set bit of a `width`-bit operand. It returns the bit index, the zero-count, a zero flag, and the operand shifted so the found bit sits at the normalised position. A valid/ready handshake and configurable register depth let it sit between mantissa-producing stages (add/mul) and exponent-adjust logic at high clock rates.

---
 rtl/svfloat_msb_pipe.sv | 146 ++++++++++++++
 tb/tb_svfloat_msb_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svfloat_msb_pipe.sv
// svfloat_msb_pipe: pipelined MSB/LSB bit finder and normaliser.
// Finds the highest (or lowest) set bit of the operand at the input, then
// carries index, zero-count, zero flag, normalised operand and tag through
// `stages` elastic register slices with valid/ready flow control.
module svfloat_msb_pipe #(
    parameter int width  = 32,
    parameter int exp    = $clog2(width),
    parameter int stages = 2,
    parameter int tag_w  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [width-1:0]  in_raw,
    input  logic              in_lsb,
    input  logic [tag_w-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [exp-1:0]    out_idx,
    output logic [exp:0]      out_cnt,
    output logic              out_zero,
    output logic [width-1:0]  out_norm,
    output logic [tag_w-1:0]  out_tag
);

    localparam int cw = exp + 1;

    // Position of the found bit, -1 when the operand is zero. In MSB mode the
    // last set bit seen wins, in LSB mode the first one does.
    function automatic int find_pos(input logic [width-1:0] raw, input logic lsb);
        int pos;
        pos = -1;
        for (int i = 0; i < width; i++) begin
            if (raw[i] && (!lsb || pos < 0)) begin
                pos = i;
            end
        end
        return pos;
    endfunction

    int                f_pos;
    logic              f_zero;
    logic [exp-1:0]    f_idx;
    logic [cw-1:0]     f_cnt;
    logic [width-1:0]  f_norm;

    logic              run;
    logic              in_fire;
    logic [stages-1:0] adv;

    logic [stages-1:0] vld_p;
    logic [exp-1:0]    idx_p  [stages];
    logic [cw-1:0]     cnt_p  [stages];
    logic              zero_p [stages];
    logic [width-1:0]  norm_p [stages];
    logic [tag_w-1:0]  tag_p  [stages];

    // Find and normalise the incoming operand.
    always_comb begin
        f_pos  = find_pos(in_raw, in_lsb);
        f_zero = (f_pos < 0);
        f_idx  = '0;
        f_cnt  = cw'(width);
        f_norm = '0;
        if (!f_zero) begin
            f_idx  = exp'(f_pos);
            f_cnt  = in_lsb ? cw'(f_pos) : cw'(width - 1 - f_pos);
            f_norm = in_lsb ? (in_raw >> f_cnt) : (in_raw << f_cnt);
        end
    end

    // A slice advances when it, or any slice downstream of it, is empty, or
    // when the consumer takes the output; this lets bubbles collapse.
    always_comb begin
        logic full;
        adv = '0;
        for (int k = 0; k < stages; k++) begin
            full = 1'b1;
            for (int j = k; j < stages; j++) begin
                full = full & vld_p[j];
            end
            adv[k] = !full || out_ready;
        end
    end

    assign in_ready = run && !clr && adv[0];
    assign in_fire  = in_valid && in_ready;

    // Pipeline slices: valid bits follow the advance chain, payload loads
    // only when a valid transaction actually moves in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run   <= 1'b0;
            vld_p <= '0;
            for (int k = 0; k < stages; k++) begin
                idx_p[k]  <= '0;
                cnt_p[k]  <= '0;
                zero_p[k] <= 1'b0;
                norm_p[k] <= '0;
                tag_p[k]  <= '0;
            end
        end else begin
            run <= 1'b1;
            if (clr) begin
                vld_p <= '0;
            end else begin
                if (adv[0]) begin
                    vld_p[0] <= in_fire;
                end
                for (int k = 1; k < stages; k++) begin
                    if (adv[k]) begin
                        vld_p[k] <= vld_p[k-1];
                    end
                end
            end
            // stage 0: capture the find result
            if (in_fire) begin
                idx_p[0]  <= f_idx;
                cnt_p[0]  <= f_cnt;
                zero_p[0] <= f_zero;
                norm_p[0] <= f_norm;
                tag_p[0]  <= in_tag;
            end
            // stages 1..N-1: shift payload forward
            for (int k = 1; k < stages; k++) begin
                if (!clr && adv[k] && vld_p[k-1]) begin
                    idx_p[k]  <= idx_p[k-1];
                    cnt_p[k]  <= cnt_p[k-1];
                    zero_p[k] <= zero_p[k-1];
                    norm_p[k] <= norm_p[k-1];
                    tag_p[k]  <= tag_p[k-1];
                end
            end
        end
    end

    assign out_valid = vld_p[stages-1];
    assign out_idx   = idx_p[stages-1];
    assign out_cnt   = cnt_p[stages-1];
    assign out_zero  = zero_p[stages-1];
    assign out_norm  = norm_p[stages-1];
    assign out_tag   = tag_p[stages-1];

endmodule

// File: tb/tb_svfloat_msb_pipe.sv
// Testbench for svfloat_msb_pipe: three instances (stages = 1, 2, 4) share
// stimulus; a scoreboard queue per instance holds reference results.
module tb_svfloat_msb_pipe;

    localparam int W  = 8;
    localparam int E  = 3;
    localparam int CW = E + 1;
    localparam int TW = 2;
    localparam int N  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_lsb = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  in_raw = '0;
    logic [TW-1:0] in_tag = '0;

    logic          ir    [N];
    logic          ov    [N];
    logic [E-1:0]  oidx  [N];
    logic [CW-1:0] ocnt  [N];
    logic          oz    [N];
    logic [W-1:0]  onorm [N];
    logic [TW-1:0] otag  [N];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            svfloat_msb_pipe #(
                .width(W), .exp(E), .stages(g == 0 ? 1 : (g == 1 ? 2 : 4)), .tag_w(TW)
            ) dut (
                .clk(clk), .rst_n(rst_n), .clr(clr),
                .in_valid(in_valid), .in_ready(ir[g]),
                .in_raw(in_raw), .in_lsb(in_lsb), .in_tag(in_tag),
                .out_valid(ov[g]), .out_ready(out_ready),
                .out_idx(oidx[g]), .out_cnt(ocnt[g]), .out_zero(oz[g]),
                .out_norm(onorm[g]), .out_tag(otag[g])
            );
        end
    endgenerate

    typedef struct {
        logic [E-1:0]  idx;
        logic [CW-1:0] cnt;
        logic          zero;
        logic [W-1:0]  norm;
        logic [TW-1:0] tag;
        int            c;
    } exp_t;

    exp_t q [N][$];
    int   stg [N] = '{1, 2, 4};

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic ran;
    int   mode = 0;
    int   drv_timeouts = 0;
    bit   fin_req = 0;
    bit   fin_done = 0;

    // Reference model: find the bit by repeated halving, normalise by
    // multiplying / dividing by a power of two.
    function automatic exp_t model(input logic [W-1:0] r, input logic l, input logic [TW-1:0] t);
        exp_t e;
        int   v, p;
        e.tag = t;
        e.c   = 0;
        if (r == 0) begin
            e.idx = '0; e.cnt = CW'(W); e.zero = 1'b1; e.norm = '0;
        end else begin
            v = int'(r);
            p = 0;
            e.zero = 1'b0;
            if (!l) begin
                while (v > 1) begin v = v / 2; p++; end
                e.idx  = E'(p);
                e.cnt  = CW'(W - 1 - p);
                e.norm = W'((int'(r) * (1 << (W - 1 - p))) % (1 << W));
            end else begin
                while (v % 2 == 0) begin v = v / 2; p++; end
                e.idx  = E'(p);
                e.cnt  = CW'(p);
                e.norm = W'(int'(r) / (1 << p));
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] pay(input int g);
        return 32'({oidx[g], ocnt[g], oz[g], onorm[g], otag[g]});
    endfunction

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s [stages=%0d] cyc=%0d: got %0h expected %0h", nm, stg[g], cyc, act, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // The block may accept input only after one clock edge out of reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ran <= 1'b0;
        else        ran <= 1'b1;
    end

    // Consumer readiness: 0 = always ready, 1 = random, 2 = stalled.
    always @(posedge clk) begin
        #1;
        if (mode == 0)      out_ready = 1'b1;
        else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else                out_ready = 1'b0;
    end

    bit          prev_stall [N];
    logic [31:0] prev_pay   [N];
    bit          prev_clr = 0;
    int          last_stall = -1;

    // Scoreboard monitor: records accepted inputs, checks every output
    // transfer, handshake behaviour and reset values.
    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        int   sz, lat;
        bit   want_ir;
        if (!rst_n) begin
            #1;
            for (int g = 0; g < N; g++) begin
                chk("reset_out_valid", g, 32'(ov[g]), 32'd0);
                chk("reset_payload", g, pay(g), 32'd0);
                chk("reset_in_ready", g, 32'(ir[g]), 32'd0);
                q[g].delete();
                prev_stall[g] = 0;
            end
            prev_clr = 0;
        end else begin
            for (int g = 0; g < N; g++) begin
                sz = q[g].size();
                want_ir = ran && !clr && !(sz == stg[g] && !out_ready);
                chk("in_ready", g, 32'(ir[g]), 32'(want_ir));
                if (prev_clr) begin
                    chk("clr_flush_valid", g, 32'(ov[g]), 32'd0);
                end else if (prev_stall[g]) begin
                    chk("stall_hold_valid", g, 32'(ov[g]), 32'd1);
                    chk("stall_hold_payload", g, pay(g), prev_pay[g]);
                end
                if (ov[g] && out_ready) begin
                    chk("output_expected", g, 32'(sz > 0), 32'd1);
                    if (sz > 0) begin
                        e = q[g].pop_front();
                        chk("idx", g, 32'(oidx[g]), 32'(e.idx));
                        chk("cnt", g, 32'(ocnt[g]), 32'(e.cnt));
                        chk("zero", g, 32'(oz[g]), 32'(e.zero));
                        chk("norm", g, 32'(onorm[g]), 32'(e.norm));
                        chk("tag", g, 32'(otag[g]), 32'(e.tag));
                        lat = cyc - e.c;
                        if (e.c > last_stall) chk("latency", g, 32'(lat), 32'(stg[g]));
                        else                  chk("latency_min", g, 32'(lat >= stg[g]), 32'd1);
                    end
                end
                prev_stall[g] = ov[g] && !out_ready;
                prev_pay[g]   = pay(g);
                if (clr) q[g].delete();
                if (in_valid && ir[g] && !clr) begin
                    e   = model(in_raw, in_lsb, in_tag);
                    e.c = cyc;
                    q[g].push_back(e);
                end
            end
            prev_clr = clr;
            if (!out_ready) last_stall = cyc;
            if (fin_req && !fin_done) begin
                chk("driver_timeouts", 1, 32'(drv_timeouts), 32'd0);
                for (int g = 0; g < N; g++) chk("results_outstanding", g, 32'(q[g].size()), 32'd0);
                fin_done = 1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Offer one operand until the stages=2 instance accepts it (bounded).
    task automatic send(input logic [W-1:0] r, input logic l, input logic [TW-1:0] t);
        int n;
        bit acc;
        in_valid = 1'b1; in_raw = r; in_lsb = l; in_tag = t;
        n = 0; acc = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = ir[1];
            @(posedge clk); #1;
            n++;
        end
        if (!acc) drv_timeouts++;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] r;
        int           n;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // directed operands, both modes, including zero
        send(8'b0001_0110, 1'b0, 2'd1);
        send(8'b0001_0110, 1'b1, 2'd2);
        send(8'h80, 1'b0, 2'd3);
        send(8'h80, 1'b1, 2'd0);
        send(8'h00, 1'b0, 2'd1);
        send(8'h00, 1'b1, 2'd2);
        send(8'h01, 1'b0, 2'd3);
        send(8'hFF, 1'b1, 2'd0);
        idle(6);

        // back-to-back stream with a stalled consumer in the middle
        fork
            begin
                for (int i = 0; i < 8; i++) send(W'($urandom), 1'($urandom_range(0, 1)), TW'(i));
            end
            begin
                idle(3); mode = 2; idle(4); mode = 0;
            end
        join
        idle(8);

        // flush while holding two results, with an input offered alongside
        mode = 2;
        idle(2);
        send(8'h3C, 1'b0, 2'd1);
        send(8'h05, 1'b1, 2'd2);
        in_valid = 1'b1; in_raw = 8'hF0; in_lsb = 1'b0; in_tag = 2'd3; clr = 1'b1;
        idle(1);
        clr = 1'b0; in_valid = 1'b0; mode = 0;
        send(8'h24, 1'b1, 2'd1);
        idle(8);

        // randomized traffic, random backpressure, occasional flush
        mode = 1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                clr = 1'b1; in_valid = 1'($urandom_range(0, 1)); in_raw = W'($urandom);
                idle(1);
                clr = 1'b0; in_valid = 1'b0;
            end
            r = W'($urandom);
            if ($urandom_range(0, 5) == 0) r = '0;
            else if ($urandom_range(0, 4) == 0) r = W'(1) << $urandom_range(0, W - 1);
            send(r, 1'($urandom_range(0, 1)), TW'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        mode = 0;
        idle(10);

        // asynchronous reset between edges with work in flight, clr overlapping
        send(8'h11, 1'b0, 2'd1);
        send(8'h22, 1'b1, 2'd2);
        send(8'h33, 1'b0, 2'd3);
        #2;
        rst_n = 1'b0;
        #4;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        send(8'h40, 1'b0, 2'd2);
        send(8'h40, 1'b1, 2'd1);
        send(8'h00, 1'b0, 2'd0);
        idle(8);

        fin_req = 1;
        n = 0;
        while (!fin_done && n < 20) begin @(posedge clk); n++; end
        if (!fin_done) $display("FAIL final_check: monitor did not complete, got 0 expected 1");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
